// File: rtl/lsu_hs_if.sv
// Request/response and data-memory handshake bundle for lsu_hs.
// Signal names follow the LSU port list, so i_/o_ are from the LSU's point of view.
interface lsu_hs_if;
    // request port
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_lsu_addr;
    logic [31:0] i_st_data;
    logic        i_lsu_wren;
    logic [2:0]  i_control;
    // response port
    logic        o_rsp_valid;
    logic        o_rsp_err;
    logic [31:0] o_ld_data;
    // data-memory port
    logic        o_mem_req;
    logic        o_mem_we;
    logic [13:0] o_mem_addr;
    logic [3:0]  o_mem_be;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;

    // LSU side
    modport slave (
        input  i_req_valid, i_lsu_addr, i_st_data, i_lsu_wren, i_control,
        input  i_mem_ack, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_err, o_ld_data,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );

    // pipeline / memory-model side
    modport master (
        output i_req_valid, i_lsu_addr, i_st_data, i_lsu_wren, i_control,
        output i_mem_ack, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_err, o_ld_data,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata
    );
endinterface

// File: rtl/lsu_hs.sv
// RV32I load-store unit: valid/ready request, registered one-cycle response,
// req/ack data-memory port with timeout, and memory-mapped LED/HEX/LCD/SW/BTN.
module lsu_hs #(
    parameter int          MEM_TIMEOUT = 255,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] LCD_RST     = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    lsu_hs_if.slave     bus,
    output logic [31:0] o_io_ledr,
    output logic [31:0] o_io_ledg,
    output logic [6:0]  o_io_hex0,
    output logic [6:0]  o_io_hex1,
    output logic [6:0]  o_io_hex2,
    output logic [6:0]  o_io_hex3,
    output logic [6:0]  o_io_hex4,
    output logic [6:0]  o_io_hex5,
    output logic [6:0]  o_io_hex6,
    output logic [6:0]  o_io_hex7,
    output logic [31:0] o_io_lcd,
    input  logic [31:0] i_io_sw,
    input  logic [3:0]  i_io_btn
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    // IO word addresses (addr[15:2])
    localparam logic [13:0] A_LEDR  = 14'h1C00;  // 0x7000
    localparam logic [13:0] A_LEDG  = 14'h1C04;  // 0x7010
    localparam logic [13:0] A_HEXLO = 14'h1C08;  // 0x7020
    localparam logic [13:0] A_HEXHI = 14'h1C09;  // 0x7024
    localparam logic [13:0] A_LCD   = 14'h1C0C;  // 0x7030
    localparam logic [13:0] A_SW    = 14'h1E00;  // 0x7800
    localparam logic [13:0] A_BTN   = 14'h1E04;  // 0x7810

    typedef enum logic [1:0] {IDLE, MEM_WAIT, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [31:0]   ld_data_q, ld_data_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [13:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [2:0]    ld_ctl_q, ld_ctl_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic [31:0]   ledr_q, ledr_d, ledg_q, ledg_d, lcd_q, lcd_d;
    logic [7:0][6:0] hex_q, hex_d;
    logic [SYNC_STAGES-1:0][31:0] sw_sync_q;
    logic [SYNC_STAGES-1:0][3:0]  btn_sync_q;

    // request decode
    logic [15:0] a;
    logic [1:0]  off;
    logic [13:0] word;
    logic [2:0]  ctl;
    logic        accept, illegal, misal, dec_err, is_dmem;
    logic [3:0]  be;
    logic [31:0] wdata, io_rdata;
    logic        unused_addr_hi;

    assign a              = bus.i_lsu_addr[15:0];
    assign off            = a[1:0];
    assign word           = a[15:2];
    assign ctl            = bus.i_control;
    assign unused_addr_hi = ^bus.i_lsu_addr[31:16];
    assign accept         = bus.i_req_valid && (state_q == IDLE);
    assign is_dmem        = (a[15:13] == 3'b001);
    assign illegal        = bus.i_lsu_wren ? (ctl > 3'b010)
                                           : (ctl == 3'b011 || ctl == 3'b110 || ctl == 3'b111);
    assign misal          = ((ctl[1:0] == 2'b01) && off[0]) || ((ctl[1:0] == 2'b10) && (off != 2'b00));
    assign dec_err        = illegal || misal;

    // Sign/zero-extend the lane selected by the byte offset.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] o,
                                             input logic [2:0] f);
        logic [31:0] sh;
        sh = w >> {o, 3'b000};
        case (f)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Overwrite only the enabled byte lanes.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] en);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (en[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    // Byte enables and lane-replicated store data
    always_comb begin
        case (ctl[1:0])
            2'b00:   begin be = 4'b0001 << off; wdata = {4{bus.i_st_data[7:0]}};  end
            2'b01:   begin be = 4'b0011 << off; wdata = {2{bus.i_st_data[15:0]}}; end
            default: begin be = 4'b1111;        wdata = bus.i_st_data;            end
        endcase
    end

    // IO read mux; unmapped addresses read as zero
    always_comb begin
        io_rdata = '0;
        case (word)
            A_LEDR:  io_rdata = ledr_q;
            A_LEDG:  io_rdata = ledg_q;
            A_HEXLO: io_rdata = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
            A_HEXHI: io_rdata = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
            A_LCD:   io_rdata = lcd_q;
            A_SW:    io_rdata = sw_sync_q[SYNC_STAGES-1];
            A_BTN:   io_rdata = {28'h0, btn_sync_q[SYNC_STAGES-1]};
            default: io_rdata = '0;
        endcase
    end

    // Next-state, response and register-file update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        ld_data_d   = '0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        ld_ctl_d    = ld_ctl_q;
        ld_off_d    = ld_off_q;
        ledr_d      = ledr_q;
        ledg_d      = ledg_q;
        lcd_d       = lcd_q;
        hex_d       = hex_q;
        case (state_q)
            IDLE: if (accept) begin
                if (dec_err) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else if (is_dmem) begin
                    state_d     = MEM_WAIT;
                    cnt_d       = '0;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.i_lsu_wren;
                    mem_addr_d  = word;
                    mem_be_d    = be;
                    mem_wdata_d = wdata;
                    ld_ctl_d    = ctl;
                    ld_off_d    = off;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    if (bus.i_lsu_wren) begin
                        case (word)
                            A_LEDR: ledr_d = merge(ledr_q, wdata, be);
                            A_LEDG: ledg_d = merge(ledg_q, wdata, be);
                            A_LCD:  lcd_d  = merge(lcd_q, wdata, be);
                            A_HEXLO: for (int k = 0; k < 4; k++)
                                if (be[k]) hex_d[k] = wdata[8*k +: 7];
                            A_HEXHI: for (int k = 0; k < 4; k++)
                                if (be[k]) hex_d[k+4] = wdata[8*k +: 7];
                            default: ;
                        endcase
                    end else begin
                        ld_data_d = load_ext(io_rdata, off, ctl);
                    end
                end
            end
            MEM_WAIT: begin
                // ack beats timeout when both land in the same cycle
                if (bus.i_mem_ack) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    ld_data_d   = mem_we_q ? '0 : load_ext(bus.i_mem_rdata, ld_off_q, ld_ctl_q);
                end else if (cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d     = RESP;
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            ld_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            ld_ctl_q    <= '0;
            ld_off_q    <= '0;
            ledr_q      <= '0;
            ledg_q      <= '0;
            lcd_q       <= LCD_RST;
            hex_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            ld_data_q   <= ld_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            ld_ctl_q    <= ld_ctl_d;
            ld_off_q    <= ld_off_d;
            ledr_q      <= ledr_d;
            ledg_q      <= ledg_d;
            lcd_q       <= lcd_d;
            hex_q       <= hex_d;
        end
    end

    // Synchronisers for the asynchronous switch/button inputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sw_sync_q  <= '0;
            btn_sync_q <= '0;
        end else begin
            sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], i_io_sw};
            btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], i_io_btn};
        end
    end

    assign bus.o_req_ready = (state_q == IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign bus.o_ld_data   = ld_data_q;
    assign bus.o_mem_req   = mem_req_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_be    = mem_be_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign o_io_ledr = ledr_q;
    assign o_io_ledg = ledg_q;
    assign o_io_lcd  = lcd_q;
    assign o_io_hex0 = hex_q[0];
    assign o_io_hex1 = hex_q[1];
    assign o_io_hex2 = hex_q[2];
    assign o_io_hex3 = hex_q[3];
    assign o_io_hex4 = hex_q[4];
    assign o_io_hex5 = hex_q[5];
    assign o_io_hex6 = hex_q[6];
    assign o_io_hex7 = hex_q[7];
endmodule

// File: tb/tb_lsu_hs.sv
// Directed bench for lsu_hs: stimulus pushes expected responses, a monitor pops and compares.
module tb_lsu_hs;
    localparam int          T       = 6;
    localparam logic [31:0] LCD_RST = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] ledr, ledg, lcd, sw;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [3:0]  btn;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    typedef struct {
        logic        err;
        logic [31:0] ld;
        int          at;
    } exp_t;
    exp_t exp_q[$];

    lsu_hs_if bus();

    lsu_hs #(.MEM_TIMEOUT(T), .SYNC_STAGES(2), .LCD_RST(LCD_RST)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus),
        .o_io_ledr(ledr), .o_io_ledg(ledg),
        .o_io_hex0(hex0), .o_io_hex1(hex1), .o_io_hex2(hex2), .o_io_hex3(hex3),
        .o_io_hex4(hex4), .o_io_hex5(hex5), .o_io_hex6(hex6), .o_io_hex7(hex7),
        .o_io_lcd(lcd), .i_io_sw(sw), .i_io_btn(btn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // response monitor / scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.o_rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rsp_unexpected: got err=%b ld=%h with nothing expected (cycle %0d)",
                         bus.o_rsp_err, bus.o_ld_data, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_cycle", cyc, e.at);
                chk("rsp_err", {31'h0, bus.o_rsp_err}, {31'h0, e.err});
                chk("rsp_ld", bus.o_ld_data, e.ld);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic [2:0] c);
        bus.i_req_valid = 1'b1;
        bus.i_lsu_addr  = a;
        bus.i_st_data   = d;
        bus.i_lsu_wren  = we;
        bus.i_control   = c;
    endtask

    // IO, unmapped or erroring request: response one cycle after accept
    task automatic io_acc(input logic [31:0] a, input logic [31:0] d, input logic we,
                          input logic [2:0] c, input logic eerr, input logic [31:0] eld);
        chk("req_ready_idle", {31'h0, bus.o_req_ready}, 32'h1);
        exp_q.push_back('{eerr, eld, cyc + 1});
        drive(a, d, we, c);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        chk("io_no_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
        @(negedge clk);
    endtask

    // DMEM request; ack driven k cycles after o_mem_req rises (or never, forcing timeout)
    task automatic mem_acc(input logic [31:0] a, input logic [31:0] d, input logic we,
                           input logic [2:0] c, input int k, input logic ack,
                           input logic [31:0] rd, input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic eerr, input logic [31:0] eld);
        exp_q.push_back('{eerr, eld, cyc + k + 1});
        drive(a, d, we, c);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        chk("mem_req", {31'h0, bus.o_mem_req}, 32'h1);
        chk("mem_addr", {18'h0, bus.o_mem_addr}, {18'h0, a[15:2]});
        chk("mem_be", {28'h0, bus.o_mem_be}, {28'h0, ebe});
        chk("mem_we", {31'h0, bus.o_mem_we}, {31'h0, we});
        if (we) chk("mem_wdata", bus.o_mem_wdata, ewd);
        chk("req_ready_wait", {31'h0, bus.o_req_ready}, 32'h0);
        for (int i = 1; i < k; i++) begin
            @(negedge clk);
            chk("mem_req_hold", {31'h0, bus.o_mem_req}, 32'h1);
            chk("mem_be_hold", {28'h0, bus.o_mem_be}, {28'h0, ebe});
        end
        if (ack) begin
            bus.i_mem_ack   = 1'b1;
            bus.i_mem_rdata = rd;
        end
        @(negedge clk);
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        chk("mem_req_drop", {31'h0, bus.o_mem_req}, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_req_valid = 1'b0;
        bus.i_lsu_addr  = '0;
        bus.i_st_data   = '0;
        bus.i_lsu_wren  = 1'b0;
        bus.i_control   = '0;
        bus.i_mem_ack   = 1'b0;
        bus.i_mem_rdata = '0;
        sw  = '0;
        btn = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_ready", {31'h0, bus.o_req_ready}, 32'h1);
        chk("rst_rsp_valid", {31'h0, bus.o_rsp_valid}, 32'h0);
        chk("rst_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
        chk("rst_mem_be", {28'h0, bus.o_mem_be}, 32'h0);
        chk("rst_ledr", ledr, 32'h0);
        chk("rst_hex0", {25'h0, hex0}, 32'h0);
        chk("rst_lcd", lcd, LCD_RST);

        // DMEM store/loads
        mem_acc(32'h2004, 32'hDEAD_BEEF, 1'b1, 3'b010, 3, 1'b1, 32'h0, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'h0);
        mem_acc(32'h2007, 32'h0, 1'b0, 3'b000, 1, 1'b1, 32'h80FF_0000, 4'b1000, 32'h0, 1'b0, 32'hFFFF_FF80);
        mem_acc(32'h2007, 32'h0, 1'b0, 3'b100, 2, 1'b1, 32'h80FF_0000, 4'b1000, 32'h0, 1'b0, 32'h0000_0080);
        mem_acc(32'h2006, 32'h0, 1'b0, 3'b001, 1, 1'b1, 32'h80FF_0000, 4'b1100, 32'h0, 1'b0, 32'hFFFF_80FF);
        mem_acc(32'h2006, 32'h0, 1'b0, 3'b101, 1, 1'b1, 32'h80FF_0000, 4'b1100, 32'h0, 1'b0, 32'h0000_80FF);
        mem_acc(32'h2001, 32'h0000_0012, 1'b1, 3'b000, 1, 1'b1, 32'h0, 4'b0010, 32'h1212_1212, 1'b0, 32'h0);
        mem_acc(32'h3FFE, 32'h0000_ABCD, 1'b1, 3'b001, 2, 1'b1, 32'h0, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0);

        // HEX registers
        io_acc(32'h7020, 32'h0403_8281, 1'b1, 3'b010, 1'b0, 32'h0);
        io_acc(32'h7022, 32'h0000_3F06, 1'b1, 3'b001, 1'b0, 32'h0);
        chk("hex0", {25'h0, hex0}, 32'h01);
        chk("hex1", {25'h0, hex1}, 32'h02);
        chk("hex2", {25'h0, hex2}, 32'h06);
        chk("hex3", {25'h0, hex3}, 32'h3F);
        io_acc(32'h7020, 32'h0, 1'b0, 3'b010, 1'b0, 32'h3F06_0201);
        io_acc(32'h7027, 32'h0000_00FF, 1'b1, 3'b000, 1'b0, 32'h0);
        chk("hex7", {25'h0, hex7}, 32'h7F);
        chk("hex4", {25'h0, hex4}, 32'h00);

        // LEDs and LCD
        io_acc(32'h7000, 32'h1234_5678, 1'b1, 3'b010, 1'b0, 32'h0);
        io_acc(32'h7001, 32'h0000_00AB, 1'b1, 3'b000, 1'b0, 32'h0);
        chk("ledr", ledr, 32'h1234_AB78);
        io_acc(32'h7000, 32'h0, 1'b0, 3'b010, 1'b0, 32'h1234_AB78);
        io_acc(32'h7002, 32'h0, 1'b0, 3'b001, 1'b0, 32'h0000_1234);
        io_acc(32'h7001, 32'h0, 1'b0, 3'b000, 1'b0, 32'hFFFF_FFAB);
        io_acc(32'h7010, 32'hCAFE_F00D, 1'b1, 3'b010, 1'b0, 32'h0);
        chk("ledg", ledg, 32'hCAFE_F00D);
        io_acc(32'h7032, 32'h0000_1122, 1'b1, 3'b001, 1'b0, 32'h0);
        chk("lcd", lcd, 32'h1122_0000);

        // errors: misaligned and illegal funct3; nothing written
        io_acc(32'h2002, 32'h0, 1'b0, 3'b010, 1'b1, 32'h0);
        io_acc(32'h2001, 32'h0, 1'b0, 3'b001, 1'b1, 32'h0);
        io_acc(32'h2000, 32'h0, 1'b0, 3'b011, 1'b1, 32'h0);
        io_acc(32'h7000, 32'hFFFF_FFFF, 1'b1, 3'b100, 1'b1, 32'h0);
        io_acc(32'h7001, 32'hFFFF_FFFF, 1'b1, 3'b001, 1'b1, 32'h0);
        chk("ledr_after_err", ledr, 32'h1234_AB78);

        // unmapped: load 0, store dropped, no error
        io_acc(32'h5000, 32'h0, 1'b0, 3'b010, 1'b0, 32'h0);
        io_acc(32'h7004, 32'hFFFF_FFFF, 1'b1, 3'b010, 1'b0, 32'h0);
        chk("ledr_after_unmapped", ledr, 32'h1234_AB78);

        // timeout, and ack on the final cycle
        mem_acc(32'h2000, 32'h0, 1'b0, 3'b010, T, 1'b0, 32'h0, 4'b1111, 32'h0, 1'b1, 32'h0);
        mem_acc(32'h2008, 32'h0, 1'b0, 3'b010, T, 1'b1, 32'h0102_0304, 4'b1111, 32'h0, 1'b0, 32'h0102_0304);

        // switch synchroniser latency
        sw = 32'h0000_005A;
        io_acc(32'h7800, 32'h0, 1'b0, 3'b010, 1'b0, 32'h0);
        io_acc(32'h7800, 32'h0, 1'b0, 3'b010, 1'b0, 32'h0000_005A);
        btn = 4'hA;
        repeat (2) @(negedge clk);
        io_acc(32'h7810, 32'h0, 1'b0, 3'b010, 1'b0, 32'h0000_000A);

        // async reset in MEM_WAIT: request drops at once, no response follows
        drive(32'h2000, 32'h0, 1'b0, 3'b010);
        @(negedge clk);
        bus.i_req_valid = 1'b0;
        chk("pre_rst_mem_req", {31'h0, bus.o_mem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_mem_req", {31'h0, bus.o_mem_req}, 32'h0);
        chk("midrst_ready", {31'h0, bus.o_req_ready}, 32'h1);
        chk("midrst_ledr", ledr, 32'h0);
        chk("midrst_hex2", {25'h0, hex2}, 32'h0);
        chk("midrst_lcd", lcd, LCD_RST);
        @(negedge clk);
        rst_n = 1'b1;
        // synchroniser restarts from zero even though sw is still 0x5A
        io_acc(32'h7800, 32'h0, 1'b0, 3'b010, 1'b0, 32'h0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
